// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store unit (master) and the memory (slave).
// One outstanding transaction; mem_ack is a single-cycle completion strobe.
interface lsu_mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: runs one req/ack bus transaction per start and returns
// an extended load result, flagging misalignment, illegal widths and bus timeouts.
module lsu_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [31:0]     addr,
    input  logic [31:0]     store_data,
    output logic            busy,
    output logic            done,
    output logic [1:0]      exc,
    output logic [31:0]     load_data,
    lsu_mem_stage_if.master mem
);

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [1:0]  exc_q, exc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] load_q, load_d;
    logic        st_q, st_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;

    logic        illegal, misaligned;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic [31:0] rshift, load_ext;

    // Request decode straight from the core-side inputs.
    always_comb begin
        illegal    = is_store ? (funct3[2] || funct3[1:0] == 2'b11)
                              : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
        misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                     (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        case (funct3[1:0])
            2'b00: begin
                be_dec    = 4'b0001 << addr[1:0];
                wdata_dec = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_dec    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_dec = {2{store_data[15:0]}};
            end
            default: begin
                be_dec    = 4'b1111;
                wdata_dec = store_data;
            end
        endcase
    end

    // Shift the addressed lane down to bit 0; word loads are always aligned so off_q is 0.
    always_comb begin
        rshift = mem.mem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_ext = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  load_ext = {24'h0, rshift[7:0]};
            3'b101:  load_ext = {16'h0, rshift[15:0]};
            default: load_ext = rshift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        cnt_d   = cnt_q;
        load_d  = load_q;
        st_d    = st_q;
        f3_d    = f3_q;
        off_d   = off_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    st_d  = is_store;
                    f3_d  = funct3;
                    off_d = addr[1:0];
                    if (illegal) begin
                        exc_d   = 2'b10;
                        state_d = StResp;
                    end else if (misaligned) begin
                        exc_d   = 2'b01;
                        state_d = StResp;
                    end else begin
                        cnt_d   = 16'd0;
                        we_d    = is_store;
                        maddr_d = {addr[31:2], 2'b00};
                        be_d    = be_dec;
                        wdata_d = wdata_dec;
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q + 16'd1;
                // An ack on the final allowed cycle still completes normally.
                if (mem.mem_ack) begin
                    exc_d   = 2'b00;
                    state_d = StResp;
                    if (!st_q) begin
                        load_d = load_ext;
                    end
                end else if (cnt_q == TimeoutLast) begin
                    exc_d   = 2'b11;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            exc_q   <= 2'b00;
            cnt_q   <= 16'd0;
            load_q  <= 32'h0;
            st_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            we_q    <= 1'b0;
            maddr_q <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
            st_q    <= st_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign busy          = (state_q == StIdle) ? start : 1'b1;
    assign done          = (state_q == StResp);
    assign exc           = exc_q;
    assign load_data     = load_q;
    assign mem.mem_req   = (state_q == StWait);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage: directed cases plus randomized transactions
// compared against an arithmetic model of widths, lanes and extension.
module tb_lsu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, busy4, done4;
    logic [1:0]  exc, exc4;
    logic [31:0] load_data, load4;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_load;

    lsu_mem_stage_if bus ();
    lsu_mem_stage_if bus4 ();

    lsu_mem_stage #(.TIMEOUT_CYCLES(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .exc        (exc),
        .load_data  (load_data),
        .mem        (bus.master)
    );

    lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut4 (
        .clk        (clk),
        .rst        (rst),
        .start      (start4),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy4),
        .done       (done4),
        .exc        (exc4),
        .load_data  (load4),
        .mem        (bus4.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: access size in bytes derived from the width field.
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic logic [1:0] m_exc(input bit st, input logic [2:0] f3,
                                         input logic [31:0] a);
        bit legal;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        if (!legal) return 2'b10;
        if (a % m_size(f3) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = m_size(f3);
        return 4'(((32'd1 << sz) - 32'd1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
        logic [31:0] w;
        int unsigned sz;
        sz = m_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v, mask;
        int unsigned sz;
        sz   = m_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        v    = (rd >> (8 * (a % 4))) & mask;
        if (f3[2] == 1'b0 && sz < 4 && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // One transaction on the main DUT; ack arrives in WAIT cycle d (d >= 1).
    task automatic txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int d,
                       input bit restart);
        logic [1:0]  ee;
        logic [3:0]  eb;
        logic [31:0] ew;
        ee = m_exc(st, f3, a);
        eb = m_be(f3, a);
        ew = m_wdata(f3, sd);
        start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
        #1;
        check("busy_on_start", 32'(busy), 32'd1);
        tick();
        start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        if (ee != 2'b00) begin
            check("err_done", 32'(done), 32'd1);
            check("err_exc", 32'(exc), 32'(ee));
            check("err_no_req", 32'(bus.mem_req), 32'd0);
            check("err_load_hold", load_data, exp_load);
            tick();
            check("err_done_pulse", 32'(done), 32'd0);
            check("err_idle_busy", 32'(busy), 32'd0);
        end else begin
            for (int c = 1; c <= d; c++) begin
                start = restart;
                check("wait_req", 32'(bus.mem_req), 32'd1);
                check("wait_we", 32'(bus.mem_we), 32'(st));
                check("wait_addr", bus.mem_addr, a & ~32'h3);
                check("wait_be", 32'(bus.mem_be), 32'(eb));
                if (st) check("wait_wdata", bus.mem_wdata, ew);
                check("wait_no_done", 32'(done), 32'd0);
                check("wait_busy", 32'(busy), 32'd1);
                bus.mem_ack   = (c == d);
                bus.mem_rdata = (c == d) ? rd : $urandom;
                tick();
            end
            bus.mem_ack = 1'b0;
            start       = 1'b0;
            if (!st) exp_load = m_load(f3, a, rd);
            check("resp_done", 32'(done), 32'd1);
            check("resp_exc", 32'(exc), 32'd0);
            check("resp_req_low", 32'(bus.mem_req), 32'd0);
            check("resp_busy", 32'(busy), 32'd1);
            check("resp_load", load_data, exp_load);
            tick();
            check("idle_done_low", 32'(done), 32'd0);
            check("idle_req_low", 32'(bus.mem_req), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start4 = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        bus4.mem_ack = 1'b0; bus4.mem_rdata = 32'h0;
        exp_load = 32'h0;
        tick(); tick();
        rst = 1'b0;
        #1;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_exc", 32'(exc), 32'd0);
        check("rst_load", load_data, 32'h0);
        check("rst_req", 32'(bus.mem_req), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 32'h0);
        check("rst_be", 32'(bus.mem_be), 32'd0);

        // Directed cases from the block's intended use.
        txn(1'b1, 3'b010, 32'h0000_1008, 32'hDEAD_BEEF, 32'h0, 1, 1'b0);
        txn(1'b1, 3'b000, 32'h0000_1003, 32'h0000_0080, 32'h0, 1, 1'b0);
        txn(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8012_3456, 1, 1'b0);
        check("lb_value", load_data, 32'hFFFF_FF80);
        txn(1'b0, 3'b100, 32'h0000_1003, 32'h0, 32'h8012_3456, 2, 1'b0);
        check("lbu_value", load_data, 32'h0000_0080);
        txn(1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_1234, 1, 1'b0);
        check("lh_value", load_data, 32'hFFFF_8001);
        txn(1'b0, 3'b101, 32'h0000_1000, 32'h0, 32'h8001_1234, 1, 1'b0);
        check("lhu_value", load_data, 32'h0000_1234);
        txn(1'b1, 3'b001, 32'h0000_1002, 32'h0000_A5C3, 32'h0, 3, 1'b0);
        txn(1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'h0, 1, 1'b0);
        txn(1'b0, 3'b011, 32'h0000_1000, 32'h0, 32'h0, 1, 1'b0);
        txn(1'b1, 3'b011, 32'h0000_1001, 32'h0, 32'h0, 1, 1'b0);
        check("illegal_wins", 32'(exc), 32'd2);
        check("lhu_survives_err", load_data, 32'h0000_1234);
        txn(1'b0, 3'b010, 32'h0000_2000, 32'h0, 32'h1357_9BDF, 5, 1'b1);

        for (int n = 0; n < 150; n++) begin
            txn(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(1, 6)), 1'($urandom));
        end

        // Bus timeout with a four-cycle limit.
        rst = 1'b1; tick(); rst = 1'b0; exp_load = 32'h0;
        start4 = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_2000;
        tick();
        start4 = 1'b0;
        check("t4_req", 32'(bus4.mem_req), 32'd1);
        bus4.mem_ack = 1'b1; bus4.mem_rdata = 32'h1234_5678;
        tick();
        bus4.mem_ack = 1'b0;
        check("t4_load_done", 32'(done4), 32'd1);
        check("t4_load_val", load4, 32'h1234_5678);
        tick();
        start4 = 1'b1; addr = 32'h0000_2004;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("t4_req_held", 32'(bus4.mem_req), 32'd1);
            check("t4_no_done", 32'(done4), 32'd0);
            tick();
        end
        check("t4_to_done", 32'(done4), 32'd1);
        check("t4_to_exc", 32'(exc4), 32'd3);
        check("t4_to_req_low", 32'(bus4.mem_req), 32'd0);
        check("t4_to_load_hold", load4, 32'h1234_5678);
        tick();
        bus4.mem_ack = 1'b1; bus4.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus4.mem_ack = 1'b0;
        check("t4_late_ack_done", 32'(done4), 32'd0);
        check("t4_late_ack_req", 32'(bus4.mem_req), 32'd0);
        check("t4_late_ack_load", load4, 32'h1234_5678);
        tick();
        check("t4_late_ack_done2", 32'(done4), 32'd0);
        start4 = 1'b1; addr = 32'h0000_2008;
        tick();
        start4 = 1'b0;
        for (int c = 1; c <= 3; c++) tick();
        bus4.mem_ack = 1'b1; bus4.mem_rdata = 32'hCAFE_F00D;
        tick();
        bus4.mem_ack = 1'b0;
        check("t4_edge_done", 32'(done4), 32'd1);
        check("t4_edge_exc", 32'(exc4), 32'd0);
        check("t4_edge_load", load4, 32'hCAFE_F00D);
        tick();

        // Reset in the middle of a WAIT abandons the access.
        txn(1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0BAD_CAFE, 1, 1'b0);
        start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_3004;
        tick();
        start = 1'b0;
        check("rw_req", 32'(bus.mem_req), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_load = 32'h0;
        check("rw_req_low", 32'(bus.mem_req), 32'd0);
        check("rw_done_low", 32'(done), 32'd0);
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_load_clr", load_data, exp_load);
        check("rw_be_clr", 32'(bus.mem_be), 32'd0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h7777_7777;
        tick();
        bus.mem_ack = 1'b0;
        check("rw_ack_ignored", 32'(done), 32'd0);
        check("rw_ack_load", load_data, exp_load);
        tick();
        check("rw_ack_ignored2", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
